// File: rtl/alu_control_seq_if.sv
// ---------------------------------------------------------------------------
// alu_control_seq_if
// Bundles the request/issue signals between the main control unit (master)
// and the registered ALU control sequencer (slave).
//   controlrequest[2:0]  request class from main control
//   funct[5:0]           instruction funct field (used when class = 000)
//   in_valid             request present this cycle
//   in_ready             sequencer can accept (combinational)
//   flush                synchronous kill of issued op and any stall
//   OpALU[OP_W-1:0]      registered ALU op code
//   op_valid             OpALU valid this cycle (one pulse per accept)
//   illegal              pulses with op_valid when the request did not decode
//   busy                 multi-cycle MULT/DIV stall in progress
// ---------------------------------------------------------------------------
interface alu_control_seq_if #(
    parameter int OP_W = 4
);
    logic [2:0]      controlrequest;
    logic [5:0]      funct;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [OP_W-1:0] OpALU;
    logic            op_valid;
    logic            illegal;
    logic            busy;

    modport master (
        output controlrequest, funct, in_valid, flush,
        input  in_ready, OpALU, op_valid, illegal, busy
    );

    modport slave (
        input  controlrequest, funct, in_valid, flush,
        output in_ready, OpALU, op_valid, illegal, busy
    );
endinterface

// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
// Registered ALU control decoder. Turns the main-control request class plus
// the funct field into an extended ALU op code, issued one cycle after the
// accepting edge. MULT and DIV hold off further requests for MUL_CYCLES /
// DIV_CYCLES cycles so that MFHI/MFLO naturally follow their completion.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_control_seq_if.slave (request in, op code / status out)
// ---------------------------------------------------------------------------
module alu_control_seq #(
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_seq_if.slave    bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MULT = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_MFHI = 4'b1101,
        OP_MFLO = 4'b1110
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic             op_valid_q, op_valid_d;
    logic             illegal_q, illegal_d;

    op_e              dec_op;
    logic             dec_illegal;
    logic             accept;

    // Ready depends only on state and flush, never on the request itself,
    // so the upstream valid can safely depend on it.
    assign bus.in_ready = (state_q == S_IDLE) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.busy     = (state_q == S_BUSY);
    assign bus.op_valid = op_valid_q;
    assign bus.illegal  = illegal_q;
    assign bus.OpALU    = OP_W'(op_q);   // upper bits beyond the 4-bit code are 0

    // Request decode.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
        unique case (bus.controlrequest)
            3'b001:  dec_op = OP_ADD;
            3'b010:  dec_op = OP_SUB;
            3'b011:  dec_op = OP_SLT;
            3'b100:  dec_op = OP_AND;
            3'b101:  dec_op = OP_OR;
            3'b110:  dec_op = OP_XOR;
            3'b111:  dec_illegal = 1'b1;
            default: begin
                // Class 000: R-type, the funct field selects the op.
                case (bus.funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b101010: dec_op = OP_SLT;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b000000: dec_op = OP_SLL;
                    6'b000010: dec_op = OP_SRL;
                    6'b000011: dec_op = OP_SRA;
                    6'b011000: dec_op = OP_MULT;
                    6'b011010: dec_op = OP_DIV;
                    6'b010000: dec_op = OP_MFHI;
                    6'b010010: dec_op = OP_MFLO;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Next-state and issue logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;        // OpALU holds on idle cycles
        op_valid_d = 1'b0;
        illegal_d  = 1'b0;

        if (bus.flush) begin
            // Flush beats both a pending request and counter expiry.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                op_d       = dec_op;
                op_valid_d = 1'b1;
                illegal_d  = dec_illegal;
                if (dec_op == OP_MULT) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(MUL_CYCLES);
                end else if (dec_op == OP_DIV) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES);
                end
            end
            // accept is impossible while BUSY, so the two branches never collide.
            if (state_q == S_BUSY) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_NOP;
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_control_seq
// Directed stimulus for alu_control_seq. The driver pushes the expected
// {op code, illegal} of every request it expects to be accepted into a
// scoreboard queue; a separate monitor pops and compares on each op_valid.
// Handshake timing (stall length, flush, reset) is checked inline.
// ---------------------------------------------------------------------------
module tb_alu_control_seq;

    localparam int OP_W = 4;
    localparam int MUL  = 4;
    localparam int DIV  = 32;

    localparam logic [3:0] C_NOP  = 4'b0000;
    localparam logic [3:0] C_ADD  = 4'b0001;
    localparam logic [3:0] C_SUB  = 4'b0010;
    localparam logic [3:0] C_MULT = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100;
    localparam logic [3:0] C_MFHI = 4'b1101;
    localparam logic [3:0] C_MFLO = 4'b1110;

    typedef struct {
        logic [3:0] op;
        logic       ill;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_control_seq_if #(.OP_W(OP_W)) bus ();

    alu_control_seq #(
        .OP_W       (OP_W),
        .MUL_CYCLES (MUL),
        .DIV_CYCLES (DIV),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic ill);
        exp_t e;
        e.op  = op;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Present a request that must be accepted at the next edge.
    task automatic send(input logic [2:0] cr, input logic [5:0] fn,
                        input logic [3:0] op, input logic ill);
        bus.controlrequest = cr;
        bus.funct          = fn;
        bus.in_valid       = 1'b1;
        #1;
        check("ready_at_send", bus.in_ready, 1);
        push_exp(op, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every issued op against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.op_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_op: got op %0h with empty scoreboard (t=%0t)",
                             bus.OpALU, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_op", 32'(bus.OpALU), 32'(e.op));
                    check("sb_illegal", bus.illegal, e.ill);
                end
            end else begin
                check("illegal_without_valid", bus.illegal, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.controlrequest = 3'b000;
        bus.funct          = 6'b000000;
        bus.in_valid       = 1'b0;
        bus.flush          = 1'b0;

        // Reset state.
        #3;
        check("rst_opalu", 32'(bus.OpALU), 0);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type sweep on consecutive edges.
        send(3'b000, 6'b100000, 4'b0001, 1'b0);
        send(3'b000, 6'b100010, 4'b0010, 1'b0);
        send(3'b000, 6'b101010, 4'b0011, 1'b0);
        send(3'b000, 6'b100100, 4'b0100, 1'b0);
        send(3'b000, 6'b100101, 4'b0101, 1'b0);
        send(3'b000, 6'b100110, 4'b0110, 1'b0);
        send(3'b000, 6'b100111, 4'b0111, 1'b0);
        send(3'b000, 6'b000000, 4'b1000, 1'b0);
        send(3'b000, 6'b000010, 4'b1001, 1'b0);
        check("sweep_op_valid", bus.op_valid, 1);
        send(3'b000, 6'b000011, 4'b1010, 1'b0);
        check("sweep_busy", bus.busy, 0);
        idle();
        check("idle_op_valid", bus.op_valid, 0);
        check("idle_opalu_hold", 32'(bus.OpALU), 32'h0000_000a);

        // Request classes 001..110 ignore funct; 111 and unknown funct are illegal.
        send(3'b001, 6'b111111, 4'b0001, 1'b0);
        send(3'b010, 6'b111111, 4'b0010, 1'b0);
        send(3'b011, 6'b111111, 4'b0011, 1'b0);
        send(3'b100, 6'b111111, 4'b0100, 1'b0);
        send(3'b101, 6'b111111, 4'b0101, 1'b0);
        send(3'b110, 6'b111111, 4'b0110, 1'b0);
        send(3'b111, 6'b000000, C_NOP, 1'b1);
        send(3'b000, 6'b111111, C_NOP, 1'b1);
        check("illegal_no_stall", bus.busy, 0);
        idle();

        // MULT: 4 stall cycles, then a held MFHI is accepted.
        send(3'b000, 6'b011000, C_MULT, 1'b0);
        bus.controlrequest = 3'b000;
        bus.funct          = 6'b010000;
        bus.in_valid       = 1'b1;
        for (int i = 0; i < MUL; i++) begin
            check("mult_stall_ready", bus.in_ready, 0);
            check("mult_stall_busy", bus.busy, 1);
            @(posedge clk);
            #1;
        end
        check("mult_done_ready", bus.in_ready, 1);
        check("mult_done_busy", bus.busy, 0);
        push_exp(C_MFHI, 1'b0);
        @(posedge clk);
        #1;
        idle();

        // DIV, flushed on the 10th edge after the accept; held ADD not taken.
        send(3'b000, 6'b011010, C_DIV, 1'b0);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush          = 1'b1;
        bus.in_valid       = 1'b1;
        bus.controlrequest = 3'b001;
        #1;
        check("div_busy_before_flush", bus.busy, 1);
        check("flush_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_busy_cleared", bus.busy, 0);
        check("flush_ready_back", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Flush in IDLE right after an issue: kills op_valid, blocks the request.
        send(3'b001, 6'b000000, C_ADD, 1'b0);
        bus.flush          = 1'b1;
        bus.controlrequest = 3'b010;
        bus.in_valid       = 1'b1;
        #1;
        check("flush_idle_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_idle_op_valid", bus.op_valid, 0);
        check("flush_idle_opalu_hold", 32'(bus.OpALU), 32'(C_ADD));
        send(3'b000, 6'b010010, C_MFLO, 1'b0);
        idle();

        // Asynchronous reset mid-DIV stall.
        send(3'b000, 6'b011010, C_DIV, 1'b0);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("div_busy_pre_reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_op_valid", bus.op_valid, 0);
        check("arst_opalu", 32'(bus.OpALU), 0);
        bus.controlrequest = 3'b001;
        bus.funct          = 6'b000000;
        bus.in_valid       = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        check("arst_release_ready", bus.in_ready, 1);
        push_exp(C_ADD, 1'b0);
        @(posedge clk);
        #1;
        check("arst_first_accept", bus.op_valid, 1);
        idle();

        // Back-to-back MULT with in_valid held: one pulse per MUL+1 cycles.
        bus.controlrequest = 3'b000;
        bus.funct          = 6'b011000;
        bus.in_valid       = 1'b1;
        #1;
        check("b2b_ready", bus.in_ready, 1);
        push_exp(C_MULT, 1'b0);
        for (int j = 0; j < 3 * (MUL + 1); j++) begin
            @(posedge clk);
            #1;
            check("b2b_op_valid", bus.op_valid, ((j % (MUL + 1)) == 0));
            check("b2b_busy", bus.busy, ((j % (MUL + 1)) != MUL));
            if ((j % (MUL + 1)) == MUL && j < 3 * (MUL + 1) - 1) begin
                push_exp(C_MULT, 1'b0);
            end
        end
        bus.in_valid = 1'b0;
        idle();
        idle();

        // Subtraction after everything settles, then drain check.
        send(3'b010, 6'b000000, C_SUB, 1'b0);
        idle();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
